// File: rtl/sram_req_arbiter.sv
// ---------------------------------------------------------------------------
// sram_req_arbiter
//
// Shares one SRAM-like bus between the IF-stage instruction port and the
// EXE-stage data port. It sits between the CPU pipeline and the AXI bridge.
// One request is granted per address handshake. Accepted transactions that
// are still waiting for data_ok are tracked in an in-order owner FIFO. Each
// bus_data_ok / bus_rdata is routed back to the port that issued the request.
//
// Parameters
//   OUTSTANDING_DEPTH  maximum number of accepted transactions still waiting
//                      for data_ok (power of 2, >= 2)
//
// Optional feature
//   SRAM_ARB_RR_EN     when defined, a tie between the ports is broken
//                      round-robin: the port that lost the last accepted
//                      handshake wins. When undefined, the data port always
//                      wins a tie and no priority register exists.
//
// Ports
//   clk, reset                 clock; synchronous active-high reset
//   inst_req/size/addr         instruction request (held until inst_addr_ok)
//   inst_addr_ok               instruction request accepted this cycle
//   inst_data_ok/rdata         instruction read data returned this cycle
//   data_req/wr/size/addr/     data request (held until data_addr_ok)
//   data_wdata
//   data_addr_ok               data request accepted this cycle
//   data_data_ok/rdata         load data valid / store complete this cycle
//   bus_req/wr/size/addr/      request towards the bridge, carrying the
//   bus_wdata                  fields of the granted port
//   bus_addr_ok                bridge accepted the bus request
//   bus_data_ok/rdata          bridge returns the oldest outstanding response
// ---------------------------------------------------------------------------
module sram_req_arbiter #(
  parameter int OUTSTANDING_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        inst_req,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  localparam int PTR_W = $clog2(OUTSTANDING_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(OUTSTANDING_DEPTH);

  // Owner of a bus transaction: which pipeline port issued it.
  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_e;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0]             count_q,      count_d;
  logic [PTR_W-1:0]             wr_ptr_q,     wr_ptr_d;
  logic [PTR_W-1:0]             rd_ptr_q,     rd_ptr_d;
  logic [OUTSTANDING_DEPTH-1:0] owner_q,      owner_d;
  logic                         lock_q,       lock_d;
  owner_e                       lock_owner_q, lock_owner_d;

  // -------------------------------------------------------------------------
  // Internal combinational signals
  // -------------------------------------------------------------------------
  logic   full;
  logic   any_req;
  owner_e grant_owner;
  logic   grant_data;
  logic   grant_inst;
  logic   push;
  logic   pop;
  owner_e head_owner;

  assign full     = (count_q == FULL_COUNT);
  assign any_req  = inst_req | data_req;

`ifdef SRAM_ARB_RR_EN
  // Preferred port on a tie; the port that lost the last accepted handshake.
  owner_e prio_q, prio_d;
`endif

  // -------------------------------------------------------------------------
  // Grant selection. While locked, the owner latched when the bridge stalled
  // keeps the bus so the request fields stay stable for the bridge, even if
  // the other port starts requesting in the meantime.
  // -------------------------------------------------------------------------
  always_comb begin
    grant_owner = OWNER_INST;
    if (lock_q) begin
      grant_owner = lock_owner_q;
    end else if (inst_req && data_req) begin
`ifdef SRAM_ARB_RR_EN
      grant_owner = prio_q;
`else
      grant_owner = OWNER_DATA;
`endif
    end else if (data_req) begin
      grant_owner = OWNER_DATA;
    end else begin
      grant_owner = OWNER_INST;
    end
  end

  assign grant_data = (grant_owner == OWNER_DATA);
  assign grant_inst = (grant_owner == OWNER_INST);

  // -------------------------------------------------------------------------
  // Bus request fields. Nothing is offered while the owner FIFO is full; a
  // pop in the full cycle only frees a slot for the following cycle. Idle
  // fields are forced to zero so the bridge never sees stale addresses.
  // -------------------------------------------------------------------------
  always_comb begin
    bus_req   = 1'b0;
    bus_wr    = 1'b0;
    bus_size  = 2'd0;
    bus_addr  = 32'd0;
    bus_wdata = 32'd0;
    if (!full && (lock_q || any_req)) begin
      bus_req = 1'b1;
      if (grant_data) begin
        bus_wr    = data_wr;
        bus_size  = data_size;
        bus_addr  = data_addr;
        bus_wdata = data_wdata;
      end else begin
        bus_size  = inst_size;
        bus_addr  = inst_addr;
      end
    end
  end

  assign push         = bus_req & bus_addr_ok;
  assign inst_addr_ok = push & grant_inst;
  assign data_addr_ok = push & grant_data;

  // -------------------------------------------------------------------------
  // Response routing. A data_ok with nothing outstanding is a bridge protocol
  // violation and is dropped without popping.
  // -------------------------------------------------------------------------
  assign head_owner   = owner_e'(owner_q[rd_ptr_q]);
  assign pop          = bus_data_ok & (count_q != '0);
  assign inst_data_ok = pop & (head_owner == OWNER_INST);
  assign data_data_ok = pop & (head_owner == OWNER_DATA);
  assign inst_rdata   = bus_rdata;
  assign data_rdata   = bus_rdata;

  // -------------------------------------------------------------------------
  // Next-state logic for the owner FIFO, outstanding count and the grant
  // lock. Pointers wrap naturally because the depth is a power of two. A
  // stall only ever happens when bus_req is high, and a lock can never meet
  // a full FIFO because the count only grows on a push, which clears it.
  // -------------------------------------------------------------------------
  always_comb begin
    owner_d      = owner_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    lock_d       = bus_req & ~bus_addr_ok;
    lock_owner_d = lock_owner_q;

    if (bus_req && !bus_addr_ok) begin
      lock_owner_d = grant_owner;
    end

    if (push) begin
      owner_d[wr_ptr_q] = grant_data;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

`ifdef SRAM_ARB_RR_EN
  // The port that was not granted at an accepted handshake is preferred at
  // the next tie.
  always_comb begin
    prio_d = prio_q;
    if (push) begin
      prio_d = grant_data ? OWNER_INST : OWNER_DATA;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q <= OWNER_DATA;
    end else begin
      prio_q <= prio_d;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // State registers. Reset drops every outstanding entry; the bridge is
  // reset in the same cycle so no stale response can arrive afterwards.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      owner_q      <= '0;
      lock_q       <= 1'b0;
      lock_owner_q <= OWNER_INST;
    end else begin
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      owner_q      <= owner_d;
      lock_q       <= lock_d;
      lock_owner_q <= lock_owner_d;
    end
  end

endmodule
